addsub_arbiter: RTL
===================

Name: addsub_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the shared AddSub unit. Accepts add/sub requests over valid/ready handshakes and drives the AddSub operand, op-code and dat_ready inputs. Captures AddSub_out, AddSub_overflow and AddSub_zero one cycle after issue, and returns them to the winning requester over a valid/ready response channel. Sits between the ALU issue path (requester 0) and the address/branch-target path (requester 1), so both can use one adder.

Parameters:
OP_ADD, 5'd6, decryptedOP code for add
OP_SUB, 5'd7, decryptedOP code for subtract
OP_IDLE, 5'd0, decryptedOP code driven when not issuing

Ports:
soc_clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 has a request
req0_ready  out  1  requester 0 request accepted this cycle
req0_a  in  32  requester 0 operand A
req0_b  in  32  requester 0 operand B
req0_sub  in  1  requester 0 op: 1 = A-B, 0 = A+B
rsp0_valid  out  1  requester 0 result valid
rsp0_ready  in  1  requester 0 consumes result
rsp0_result  out  32  result
rsp0_carry  out  1  AddSub_overflow (carry-out bit 32)
rsp0_zero  out  1  AddSub_zero
req1_*, rsp1_*  (same set as requester 0)  requester 1 channel
dat_ready  out  1  to AddSub: operands valid
ALU_dat1  out  32  to AddSub: operand A
ALU_dat2  out  32  to AddSub: operand B (un-negated; AddSub negates for SUB)
decryptedOP  out  5  to AddSub: OP_ADD / OP_SUB / OP_IDLE
AddSub_out  in  32  from AddSub
AddSub_overflow  in  1  from AddSub
AddSub_zero  in  1  from AddSub

Behaviour:
- Reset (reset=0, async):
  - state IDLE, priority pointer = 0.
  - All outputs 0; decryptedOP = OP_IDLE.
  - Any in-flight request or held response is discarded.
- One transaction outstanding at a time. FSM states: IDLE, ISSUE, CAPTURE, RESPOND.
- IDLE:
  - Grant is combinational. If only one reqX_valid is high, that requester wins. If both are high, the priority pointer picks.
  - reqX_ready = 1 only for the winner. No grant if neither valid.
  - On handshake (valid & ready at the edge): latch a, b, sub and winner id into holding regs; go to ISSUE.
- ISSUE (1 cycle):
  - dat_ready = 1.
  - ALU_dat1/ALU_dat2 = held operands.
  - decryptedOP = OP_SUB if sub, else OP_ADD.
  - Go to CAPTURE.
- CAPTURE (1 cycle):
  - dat_ready = 0, decryptedOP = OP_IDLE, operands = 0.
  - At the ending edge, register AddSub_out, AddSub_overflow and AddSub_zero into the response regs; go to RESPOND.
- RESPOND:
  - rspX_valid = 1 for the held winner only.
  - result/carry/zero stay stable until rspX_ready = 1.
  - On handshake: go to IDLE; pointer := other requester.
- Latency: request accepted in cycle c gives rspX_valid = 1 in cycle c+3. Minimum issue interval is 4 cycles (rsp_ready tied high).
- While state != IDLE, both reqX_ready = 0, regardless of valid.
- Outside ISSUE: dat_ready = 0, ALU_dat1 = ALU_dat2 = 0, decryptedOP = OP_IDLE.
- rsp outputs for the non-winner are 0. Response data are 0 when rspX_valid = 0.
- Widths: operands and results are pass-through 32 bits. The arbiter does no arithmetic. Carry semantics follow AddSub: a SUB with no borrow (A >= B unsigned) gives carry = 1.
- Pointer is updated only on a response handshake. A lone requester may be granted repeatedly with no fairness penalty.
- Requester deasserting valid before the handshake: no grant, no state change.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. After release, the first simultaneous request goes to requester 0.

Test Plan:
- Single add: req0 a=5, b=7, sub=0 accepted in cycle c -> dat_ready=1 and decryptedOP=6 in cycle c+1; rsp0_valid in cycle c+3 with result=12, carry=0, zero=0.
- Sub cases on requester 1: 5-5 -> result 0, zero=1, carry=1. 3-5 -> result 0xFFFFFFFE, zero=0, carry=0. decryptedOP=7 in the issue cycle.
- Add wrap: 0xFFFFFFFF+1 -> result 0, carry=1, zero=1.
- Contention: both valid continuously from reset, rsp_ready tied 1 -> grant order 0,1,0,1. Each rsp appears only on the granted channel, and accepts are 4 cycles apart.
- Backpressure: hold rsp0_ready=0 for 5 cycles with req1_valid=1 -> rsp0 data stable, req1_ready=0 throughout; req1 granted in the cycle after the rsp0 handshake.
- Async reset asserted during CAPTURE -> all outputs 0 immediately, no rsp_valid after release. A subsequent simultaneous request grants requester 0 first.

Source files
------------

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for the shared AddSub unit.
// One transaction at a time: grant in IDLE, drive operands in ISSUE,
// sample the unit's registered result in CAPTURE, hold it in RESPOND
// until the winning requester takes it.
module addsub_arbiter #(
  parameter logic [4:0] OP_ADD  = 5'd6,
  parameter logic [4:0] OP_SUB  = 5'd7,
  parameter logic [4:0] OP_IDLE = 5'd0
) (
  input  logic        soc_clk,
  input  logic        reset,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_carry,
  output logic        rsp0_zero,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_carry,
  output logic        rsp1_zero,

  output logic        dat_ready,
  output logic [31:0] ALU_dat1,
  output logic [31:0] ALU_dat2,
  output logic [4:0]  decryptedOP,
  input  logic [31:0] AddSub_out,
  input  logic        AddSub_overflow,
  input  logic        AddSub_zero
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t      state_q;
  logic        ptr_q;       // requester favoured on a tie
  logic        win_q;       // requester owning the current transaction
  logic        dat_ready_q;
  logic [31:0] alu_dat1_q;
  logic [31:0] alu_dat2_q;
  logic [4:0]  op_q;
  logic [1:0]  rsp_vld_q;   // one-hot per requester, only set in RESPOND
  logic [31:0] res_q;
  logic        carry_q;
  logic        zero_q;

  logic        grant0;
  logic        grant1;
  logic [31:0] a_d;
  logic [31:0] b_d;
  logic        sub_d;
  logic        rsp_hs;

  // Combinational grant: only in IDLE and never while reset is held, so
  // req*_ready reads 0 during reset along with every other output.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset && (state_q == IDLE)) begin
      if (req0_valid && (!req1_valid || !ptr_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    a_d   = grant1 ? req1_a   : req0_a;
    b_d   = grant1 ? req1_b   : req0_b;
    sub_d = grant1 ? req1_sub : req0_sub;
  end

  assign rsp_hs = (rsp_vld_q[0] && rsp0_ready) || (rsp_vld_q[1] && rsp1_ready);

  // Transaction sequencer; all AddSub-facing and response outputs are registered here.
  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      win_q       <= 1'b0;
      dat_ready_q <= 1'b0;
      alu_dat1_q  <= '0;
      alu_dat2_q  <= '0;
      op_q        <= OP_IDLE;
      rsp_vld_q   <= 2'b00;
      res_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            // The operand registers double as the request holding registers.
            win_q       <= grant1;
            dat_ready_q <= 1'b1;
            alu_dat1_q  <= a_d;
            alu_dat2_q  <= b_d;
            op_q        <= sub_d ? OP_SUB : OP_ADD;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          dat_ready_q <= 1'b0;
          alu_dat1_q  <= '0;
          alu_dat2_q  <= '0;
          op_q        <= OP_IDLE;
          state_q     <= CAPTURE;
        end
        CAPTURE: begin
          // AddSub presents its result the cycle after dat_ready.
          res_q     <= AddSub_out;
          carry_q   <= AddSub_overflow;
          zero_q    <= AddSub_zero;
          rsp_vld_q <= win_q ? 2'b10 : 2'b01;
          state_q   <= RESPOND;
        end
        RESPOND: begin
          if (rsp_hs) begin
            rsp_vld_q <= 2'b00;
            res_q     <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            ptr_q     <= ~win_q;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;

  assign dat_ready   = dat_ready_q;
  assign ALU_dat1    = alu_dat1_q;
  assign ALU_dat2    = alu_dat2_q;
  assign decryptedOP = op_q;

  // Response data is steered only to the owning channel; the other reads 0.
  assign rsp0_valid  = rsp_vld_q[0];
  assign rsp0_result = rsp_vld_q[0] ? res_q   : 32'd0;
  assign rsp0_carry  = rsp_vld_q[0] ? carry_q : 1'b0;
  assign rsp0_zero   = rsp_vld_q[0] ? zero_q  : 1'b0;

  assign rsp1_valid  = rsp_vld_q[1];
  assign rsp1_result = rsp_vld_q[1] ? res_q   : 32'd0;
  assign rsp1_carry  = rsp_vld_q[1] ? carry_q : 1'b0;
  assign rsp1_zero   = rsp_vld_q[1] ? zero_q  : 1'b0;

endmodule
